gen_scheduler: RTL and testbench
================================

GEN_SCHEDULER -- requirements
Module: gen_scheduler

Interface
REQ-001 SHALL have port clk  in  1  sole clock; all state updates on its rising edge.
REQ-002 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL have port i_cmd_run_toggle  in  1  one-cycle pulse; toggles RUN/PAUSE.
REQ-004 SHALL have port i_cmd_step  in  1  one-cycle pulse; requests one generation while paused.
REQ-005 SHALL have port i_speed_sel  in  2  index into GEN_PERIOD_FRAMES.
REQ-006 SHALL have port i_frame_tick  in  1  one-cycle pulse per display frame.
REQ-007 SHALL have port i_fcl_req  in  1  field config loader holds a pending request (request != NO_REQ).
REQ-008 SHALL have port i_fcl_busy  in  1  field config loader is loading.
REQ-009 SHALL have port i_step_busy  in  1  generation engine busy; high from the cycle after o_step_go until completion.
REQ-010 SHALL have port o_fcl_allowed  out  1  field memory granted to loader.
REQ-011 SHALL have port o_step_go  out  1  one-cycle start pulse to generation engine.
REQ-012 SHALL have port o_running  out  1  RUN mode flag.
REQ-013 SHALL have port o_gen_count  out  GEN_CNT_W (16)  generations completed since last load/reset.

Function
REQ-014 SHALL implement FSM states IDLE, STEP_GO, STEP_WAIT, LOAD_GRANT.
REQ-015 IDLE: if i_fcl_req -> LOAD_GRANT (loader has priority); else if step_pending -> STEP_GO, step_pending cleared same edge.
REQ-016 STEP_GO: o_step_go = 1 for exactly this cycle; unconditionally -> STEP_WAIT.
REQ-017 STEP_WAIT: on !i_step_busy -> IDLE and o_gen_count increments by 1, wrapping 0xFFFF -> 0x0000.
REQ-018 LOAD_GRANT: o_fcl_allowed = 1; on !i_fcl_req && !i_fcl_busy -> IDLE, o_gen_count <= 0, running <= 0, frame counter <= 0, step_pending <= 0.
REQ-019 o_fcl_allowed SHALL be high iff state == LOAD_GRANT; o_step_go high iff state == STEP_GO.
REQ-020 i_cmd_run_toggle SHALL invert running on the next edge, in any state except the exit edge of LOAD_GRANT (clear wins).
REQ-021 While running, frame counter SHALL increment on i_frame_tick; on a tick with counter >= GEN_PERIOD_FRAMES[i_speed_sel]-1, counter <= 0 and step_pending <= 1.
REQ-022 While paused, frame counter SHALL hold; i_cmd_step SHALL set step_pending; i_cmd_step while running SHALL be ignored.
REQ-023 i_cmd_run_toggle and i_cmd_step in the same cycle: toggle applied, step ignored.
REQ-024 step_pending SHALL saturate at 1: triggers during STEP_GO/STEP_WAIT/LOAD_GRANT coalesce into one pending generation; no queuing.
REQ-025 i_speed_sel change mid-count SHALL take effect on the next tick (>= comparison fires immediately if already past new period).
REQ-026 A new generation SHALL never start while o_fcl_allowed is high, and grant SHALL never be given while in STEP_GO/STEP_WAIT.

Reset
REQ-027 On rst: state = IDLE, running = 0, step_pending = 0, frame counter = 0, o_gen_count = 0, o_step_go = 0, o_fcl_allowed = 0.
REQ-028 rst mid-STEP_WAIT or mid-LOAD_GRANT SHALL return to IDLE next edge, discarding in-flight work; outputs low the cycle after rst.

Structure
REQ-029 Package defs SHALL hold gen_sched_state_t, GEN_CNT_W = 16, SPEED_SEL_W = 2, GEN_PERIOD_FRAMES = {60, 30, 10, 2} (indices 0..3).
REQ-030 Frame counter and step_pending SHALL be a sub-module gen_period_timer (inputs: running, tick, speed_sel, manual step, consume, clear; output: step_pending).

Verification
REQ-031 Run, speed_sel=3, i_step_busy low 4 cycles after each go -> o_step_go on every 2nd i_frame_tick; 10 ticks -> o_gen_count = 5.
REQ-032 Paused, i_cmd_step once -> one o_step_go, o_gen_count 0 -> 1; i_cmd_step while running -> no extra go.
REQ-033 Running, period due and i_fcl_req rising in the same cycle in IDLE -> LOAD_GRANT first; after loader finishes, o_running = 0, o_gen_count = 0, no o_step_go issued.
REQ-034 Running, engine busy 200 cycles, speed_sel=3, 3 ticks during busy -> exactly one further o_step_go after completion.
REQ-035 o_gen_count preset 0xFFFF via 65535 steps (or forced), one step -> 0x0000.
REQ-036 rst asserted during STEP_WAIT -> next cycle all outputs 0, state IDLE, pending cleared.

Source files
------------

// File: rtl/gen_scheduler_pkg.sv
// Shared types and constants for the generation scheduler: FSM state, counter
// widths and the frames-per-generation table selected by speed_sel.
package gen_scheduler_pkg;

    localparam int GEN_CNT_W   = 16;
    localparam int SPEED_SEL_W = 2;
    localparam int FRAME_CNT_W = 6;

    // Index 0 is the slowest rate (60 frames per generation), index 3 the fastest.
    localparam logic [3:0][FRAME_CNT_W-1:0] GEN_PERIOD_FRAMES = {6'd2, 6'd10, 6'd30, 6'd60};

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        STEP_GO    = 2'd1,
        STEP_WAIT  = 2'd2,
        LOAD_GRANT = 2'd3
    } gen_sched_state_t;

    function automatic logic [FRAME_CNT_W-1:0] period_last(input logic [SPEED_SEL_W-1:0] sel);
        return GEN_PERIOD_FRAMES[sel] - FRAME_CNT_W'(1);
    endfunction

endpackage

// File: rtl/gen_scheduler_period_timer.sv
// Frame counter plus a single saturating "generation pending" flag, set either by
// the frame period elapsing while running or by a manual step while paused.
module gen_period_timer
    import gen_scheduler_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   running,
    input  logic                   tick,
    input  logic [SPEED_SEL_W-1:0] speed_sel,
    input  logic                   manual_step,
    input  logic                   consume,
    input  logic                   clear,
    output logic                   step_pending
);

    logic [FRAME_CNT_W-1:0] frame_cnt;
    logic                   period_due;
    logic                   trigger;

    // >= rather than == so a speed change to a shorter period fires on the next tick.
    assign period_due = running && tick && (frame_cnt >= period_last(speed_sel));
    assign trigger    = period_due || (manual_step && !running);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            frame_cnt    <= '0;
            step_pending <= 1'b0;
        end else begin
            if (running && tick) begin
                frame_cnt <= period_due ? '0 : frame_cnt + FRAME_CNT_W'(1);
            end
            // A trigger on the consume edge is a fresh request, so it wins.
            if (trigger) begin
                step_pending <= 1'b1;
            end else if (consume) begin
                step_pending <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/gen_scheduler.sv
// Arbitrates the field memory between the config loader and the generation engine
// and paces generations from frame ticks or manual steps.
module gen_scheduler
    import gen_scheduler_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_cmd_run_toggle,
    input  logic                   i_cmd_step,
    input  logic [SPEED_SEL_W-1:0] i_speed_sel,
    input  logic                   i_frame_tick,
    input  logic                   i_fcl_req,
    input  logic                   i_fcl_busy,
    input  logic                   i_step_busy,
    output logic                   o_fcl_allowed,
    output logic                   o_step_go,
    output logic                   o_running,
    output logic [GEN_CNT_W-1:0]   o_gen_count,
    output gen_sched_state_t       dbg_state
);

    // Handshakes: o_step_go is a one-cycle start; the engine then holds i_step_busy
    // high from the next cycle until done. The loader holds i_fcl_req until granted,
    // and the grant is held until both i_fcl_req and i_fcl_busy are low.
    gen_sched_state_t state;
    logic             step_pending;
    logic             consume;
    logic             load_exit;
    logic             manual_step;

    assign load_exit   = (state == LOAD_GRANT) && !i_fcl_req && !i_fcl_busy;
    assign consume     = (state == IDLE) && !i_fcl_req && step_pending;
    assign manual_step = i_cmd_step && !i_cmd_run_toggle;
    assign dbg_state   = state;

    gen_period_timer u_timer (
        .clk          (clk),
        .rst          (rst),
        .running      (o_running),
        .tick         (i_frame_tick),
        .speed_sel    (i_speed_sel),
        .manual_step  (manual_step),
        .consume      (consume),
        .clear        (load_exit),
        .step_pending (step_pending)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            o_running     <= 1'b0;
            o_gen_count   <= '0;
            o_step_go     <= 1'b0;
            o_fcl_allowed <= 1'b0;
        end else begin
            o_step_go <= 1'b0;
            if (load_exit) begin
                o_running <= 1'b0;
            end else if (i_cmd_run_toggle) begin
                o_running <= ~o_running;
            end
            case (state)
                IDLE: begin
                    if (i_fcl_req) begin
                        state         <= LOAD_GRANT;
                        o_fcl_allowed <= 1'b1;
                    end else if (step_pending) begin
                        state     <= STEP_GO;
                        o_step_go <= 1'b1;
                    end
                end
                STEP_GO: state <= STEP_WAIT;
                STEP_WAIT: begin
                    if (!i_step_busy) begin
                        state       <= IDLE;
                        o_gen_count <= o_gen_count + GEN_CNT_W'(1);
                    end
                end
                LOAD_GRANT: begin
                    if (load_exit) begin
                        state         <= IDLE;
                        o_fcl_allowed <= 1'b0;
                        o_gen_count   <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gen_scheduler.sv
// Bench for gen_scheduler: directed scenarios plus a randomized run, all outputs
// compared every cycle against a behavioural model through an expected queue.
module tb_gen_scheduler;
    import gen_scheduler_pkg::*;

    logic                   clk;
    logic                   rst;
    logic                   i_cmd_run_toggle;
    logic                   i_cmd_step;
    logic [1:0]             i_speed_sel;
    logic                   i_frame_tick;
    logic                   i_fcl_req;
    logic                   i_fcl_busy;
    logic                   i_step_busy;
    logic                   o_fcl_allowed;
    logic                   o_step_go;
    logic                   o_running;
    logic [15:0]            o_gen_count;
    gen_sched_state_t       dbg_state;

    int tests = 0;
    int fails = 0;
    int n_go  = 0;
    int eng_len = 4;
    int busy_left = 0;
    int fcl_len = 3;
    int fcl_kicks = 0;
    int fcl_served = 0;
    int fcl_phase = 0;
    int fcl_left = 0;
    int periods[4] = '{60, 30, 10, 2};

    logic [18:0] exp_q[$];

    // Reference model: generation-level view of the scheduler
    logic        m_run, m_pend, m_launch, m_engine, m_load;
    int          m_frames;
    logic [15:0] m_gen;
    logic        n_run, n_pend, n_launch, n_engine, n_load;
    int          n_frames;
    logic [15:0] n_gen;
    logic        m_idle, m_done, m_fire, m_manual, m_take;

    gen_scheduler dut (
        .clk              (clk),
        .rst              (rst),
        .i_cmd_run_toggle (i_cmd_run_toggle),
        .i_cmd_step       (i_cmd_step),
        .i_speed_sel      (i_speed_sel),
        .i_frame_tick     (i_frame_tick),
        .i_fcl_req        (i_fcl_req),
        .i_fcl_busy       (i_fcl_busy),
        .i_step_busy      (i_step_busy),
        .o_fcl_allowed    (o_fcl_allowed),
        .o_step_go        (o_step_go),
        .o_running        (o_running),
        .o_gen_count      (o_gen_count),
        .dbg_state        (dbg_state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model update on each active edge, expected post-edge outputs queued
    always @(posedge clk) begin
        if (rst) begin
            m_run = 0; m_pend = 0; m_launch = 0; m_engine = 0; m_load = 0;
            m_frames = 0; m_gen = 16'h0;
        end else begin
            m_idle   = !m_launch && !m_engine && !m_load;
            m_done   = m_load && !i_fcl_req && !i_fcl_busy;
            m_fire   = m_run && i_frame_tick && (m_frames + 1 >= periods[i_speed_sel]);
            m_manual = i_cmd_step && !i_cmd_run_toggle && !m_run;
            m_take   = m_idle && !i_fcl_req && m_pend;

            n_frames = m_frames;
            if (m_done) n_frames = 0;
            else if (m_run && i_frame_tick) n_frames = m_fire ? 0 : m_frames + 1;

            n_pend = m_pend;
            if (m_done) n_pend = 0;
            else if (m_fire || m_manual) n_pend = 1;
            else if (m_take) n_pend = 0;

            n_run = m_run;
            if (m_done) n_run = 0;
            else if (i_cmd_run_toggle) n_run = !m_run;

            n_launch = m_take;
            n_engine = m_launch || (m_engine && i_step_busy);
            n_load   = (m_idle && i_fcl_req) || (m_load && !m_done);
            n_gen    = m_gen;
            if (m_engine && !i_step_busy) n_gen = m_gen + 16'd1;
            if (m_done) n_gen = 16'h0;

            m_run = n_run; m_pend = n_pend; m_launch = n_launch; m_engine = n_engine;
            m_load = n_load; m_frames = n_frames; m_gen = n_gen;
        end
        exp_q.push_back({m_launch, m_load, m_run, m_gen});
    end

    // Monitor / scoreboard
    always @(negedge clk) begin
        logic [18:0] exp_v;
        logic [18:0] got_v;
        tests++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL queue_empty t=%0t no expected entry", $time);
        end else begin
            exp_v = exp_q.pop_front();
            got_v = {o_step_go, o_fcl_allowed, o_running, o_gen_count};
            if (got_v !== exp_v) begin
                fails++;
                $display("FAIL cycle_outputs t=%0t got go=%b grant=%b run=%b gen=%h exp go=%b grant=%b run=%b gen=%h",
                         $time, got_v[18], got_v[17], got_v[16], got_v[15:0],
                         exp_v[18], exp_v[17], exp_v[16], exp_v[15:0]);
            end
        end
        if (o_step_go) n_go++;
    end

    // Generation engine responder
    always @(negedge clk) begin
        if (o_step_go) busy_left = eng_len;
        i_step_busy = (busy_left != 0);
        if (busy_left != 0) busy_left--;
    end

    // Field config loader responder
    always @(negedge clk) begin
        if (fcl_phase == 0 && fcl_kicks != fcl_served) begin
            fcl_served++;
            i_fcl_req = 1'b1;
            fcl_phase = 1;
        end else if (fcl_phase == 1 && o_fcl_allowed) begin
            i_fcl_req  = 1'b0;
            i_fcl_busy = 1'b1;
            fcl_left   = fcl_len;
            fcl_phase  = 2;
        end else if (fcl_phase == 2) begin
            if (fcl_left == 0) begin
                i_fcl_busy = 1'b0;
                fcl_phase  = 0;
            end else begin
                fcl_left--;
            end
        end
    end

    // Driver tasks
    task automatic step_cycle();
        @(posedge clk);
        @(negedge clk);
        #1;
        i_cmd_run_toggle = 1'b0;
        i_cmd_step       = 1'b0;
        i_frame_tick     = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) step_cycle();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_cycles(2);
        rst = 1'b0;
    endtask

    task automatic tick_and_wait(input int n);
        i_frame_tick = 1'b1;
        step_cycle();
        idle_cycles(n);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        i_cmd_run_toggle = 1'b0;
        i_cmd_step = 1'b0;
        i_speed_sel = 2'd3;
        i_frame_tick = 1'b0;
        i_fcl_req = 1'b0;
        i_fcl_busy = 1'b0;
        idle_cycles(2);
        check("reset_outputs", {28'h0, o_step_go, o_fcl_allowed, o_running, 1'b0}, 32'h0);
        check("reset_gen_count", 32'(o_gen_count), 32'h0);
        check("reset_state", 32'(dbg_state), 32'(IDLE));
        rst = 1'b0;

        // Fastest rate: a generation every second tick
        eng_len = 4;
        n_go = 0;
        i_cmd_run_toggle = 1'b1;
        step_cycle();
        for (int i = 0; i < 10; i++) tick_and_wait(11);
        check("run_sel3_go_count", 32'(n_go), 32'd5);
        check("run_sel3_gen_count", 32'(o_gen_count), 32'd5);

        // Manual step while paused, ignored while running
        do_reset();
        n_go = 0;
        i_cmd_step = 1'b1;
        step_cycle();
        idle_cycles(10);
        check("manual_step_go", 32'(n_go), 32'd1);
        check("manual_step_gen", 32'(o_gen_count), 32'd1);
        i_cmd_run_toggle = 1'b1;
        step_cycle();
        i_cmd_step = 1'b1;
        step_cycle();
        idle_cycles(10);
        check("step_while_running", 32'(n_go), 32'd1);

        // Loader request and due period in the same cycle: loader first, then cleared
        do_reset();
        i_cmd_run_toggle = 1'b1;
        step_cycle();
        tick_and_wait(0);
        tick_and_wait(10);
        check("pre_load_gen", 32'(o_gen_count), 32'd1);
        tick_and_wait(0);
        n_go = 0;
        fcl_len = 3;
        fcl_kicks++;
        step_cycle();
        tick_and_wait(15);
        check("load_no_go", 32'(n_go), 32'd0);
        check("load_running_cleared", {31'h0, o_running}, 32'd0);
        check("load_gen_cleared", 32'(o_gen_count), 32'd0);

        // Long engine busy: ticks during busy coalesce into one generation
        do_reset();
        n_go = 0;
        eng_len = 200;
        i_cmd_run_toggle = 1'b1;
        step_cycle();
        tick_and_wait(0);
        tick_and_wait(10);
        eng_len = 4;
        for (int i = 0; i < 3; i++) tick_and_wait(20);
        idle_cycles(160);
        check("busy_coalesce_go", 32'(n_go), 32'd2);

        // Generation counter wrap
        do_reset();
        force dut.o_gen_count = 16'hFFFF;
        m_gen = 16'hFFFF;
        step_cycle();
        release dut.o_gen_count;
        step_cycle();
        check("preset_ffff", 32'(o_gen_count), 32'h0000FFFF);
        i_cmd_step = 1'b1;
        step_cycle();
        idle_cycles(10);
        check("gen_wrap", 32'(o_gen_count), 32'h0);

        // Reset during STEP_WAIT discards the generation
        do_reset();
        eng_len = 50;
        i_cmd_step = 1'b1;
        step_cycle();
        idle_cycles(5);
        check("pre_rst_state", 32'(dbg_state), 32'(STEP_WAIT));
        rst = 1'b1;
        step_cycle();
        check("rst_wait_outputs", {28'h0, o_step_go, o_fcl_allowed, o_running, 1'b0}, 32'h0);
        check("rst_wait_gen", 32'(o_gen_count), 32'h0);
        check("rst_wait_state", 32'(dbg_state), 32'(IDLE));
        rst = 1'b0;
        n_go = 0;
        idle_cycles(60);
        check("rst_wait_no_go", 32'(n_go), 32'd0);

        // Randomized traffic
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            eng_len = $urandom_range(1, 6);
            fcl_len = $urandom_range(0, 5);
            i_frame_tick     = ($urandom_range(0, 3) == 0);
            i_cmd_run_toggle = ($urandom_range(0, 39) == 0);
            i_cmd_step       = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 49) == 0) i_speed_sel = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 199) == 0) fcl_kicks++;
            rst = ($urandom_range(0, 799) == 0);
            step_cycle();
        end
        rst = 1'b0;
        idle_cycles(50);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
